demux_arbiter: RTL and testbench

//   Round-robin arbiter sharing one demux-selected resource among REQUESTERS clients.

---
 rtl/demux_arbiter_pkg.sv | 7 +
 rtl/demux_arbiter_demux.sv | 16 +
 rtl/demux_arbiter.sv | 147 ++++++++++++++
 tb/tb_demux_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/demux_arbiter_pkg.sv
// Shared FSM state encodings for the round-robin demux arbiter.
package demux_arbiter_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

endpackage

// File: rtl/demux_arbiter_demux.sv
// Enable/selector demux that produces the one-hot grant from the owner index.
module demux #(
  parameter  int OUTPUT_WIDTH = 2,
  localparam int SEL_W        = (OUTPUT_WIDTH > 1) ? $clog2(OUTPUT_WIDTH) : 1
) (
  input  logic                    enable,
  input  logic [SEL_W-1:0]        selector,
  output logic [OUTPUT_WIDTH-1:0] out
);

  always_comb begin
    out = '0;
    if (enable) out[selector] = 1'b1;
  end

endmodule

// File: rtl/demux_arbiter.sv
// Round-robin arbiter owning one demux-steered resource; grant held until release.
// Optional grant revoke timer enabled by defining DEMUX_ARBITER_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | no owner; arbitrate eligible requests from the pointer
// ST_GRANT | grant_id owns the resource until its req drops (or the timer expires)
module demux_arbiter
  import demux_arbiter_pkg::*;
#(
  parameter  int REQUESTERS     = 5,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int SEL_W          = $clog2(REQUESTERS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REQUESTERS-1:0] req,
  output logic [REQUESTERS-1:0] grant,
  output logic                  grant_valid,
  output logic [SEL_W-1:0]      grant_id,
  output logic                  timeout
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(REQUESTERS - 1);

  logic [0:0]            state_q, state_d;
  logic                  valid_q, valid_d;
  logic [SEL_W-1:0]      id_q, id_d;
  logic [SEL_W-1:0]      ptr_q, ptr_d;
  logic [REQUESTERS-1:0] elig;
  logic [SEL_W-1:0]      pick;

  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + SEL_W'(1);
  endfunction

  // Scan every index once starting at the pointer; result only used when |elig.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [REQUESTERS-1:0] e,
                                               input logic [SEL_W-1:0]      ptr);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    idx     = ptr;
    found   = 1'b0;
    for (int n = 0; n < REQUESTERS; n++) begin
      if (!found && e[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
      idx = next_idx(idx);
    end
  endfunction

  assign pick        = rr_pick(elig, ptr_q);
  assign grant_valid = valid_q;
  assign grant_id    = id_q;

`ifdef DEMUX_ARBITER_TIMEOUT_EN
  localparam int             CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [REQUESTERS-1:0] blocked_q, blocked_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  to_q, to_d;

  assign elig    = req & ~blocked_q;
  assign timeout = to_q;
`else
  assign elig    = req;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
`ifdef DEMUX_ARBITER_TIMEOUT_EN
    to_d      = 1'b0;
    blocked_d = blocked_q & req;
    cnt_d     = (state_q == ST_GRANT) ? cnt_q + CNT_W'(1) : '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          state_d = ST_GRANT;
          valid_d = 1'b1;
          id_d    = pick;
          ptr_d   = next_idx(pick);
        end
      end
      ST_GRANT: begin
        // Release takes priority over expiry.
        if (!req[id_q]) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
`ifdef DEMUX_ARBITER_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d         = ST_IDLE;
          valid_d         = 1'b0;
          to_d            = 1'b1;
          blocked_d[id_q] = 1'b1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef DEMUX_ARBITER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blocked_q <= '0;
      cnt_q     <= '0;
      to_q      <= 1'b0;
    end else begin
      blocked_q <= blocked_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
    end
  end
`endif

  demux #(.OUTPUT_WIDTH(REQUESTERS)) u_demux (
    .enable   (valid_q),
    .selector (id_q),
    .out      (grant)
  );

endmodule

// File: tb/tb_demux_arbiter.sv
// Directed bench for demux_arbiter (REQUESTERS=5, TIMEOUT_CYCLES=8), both macro builds.
module tb_demux_arbiter;

  logic       clk;
  logic       rst_n;
  logic [4:0] req;
  logic [4:0] grant;
  logic       grant_valid;
  logic [2:0] grant_id;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  demux_arbiter #(.REQUESTERS(5), .TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_owner(input string tag, input int id);
    chk({tag, "_valid"}, 32'(grant_valid), 32'd1);
    chk({tag, "_id"}, 32'(grant_id), 32'(id));
    chk({tag, "_grant"}, 32'(grant), 32'(1) << id);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(grant_valid), 32'd0);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 5'b11111;
    step();
    step();
    chk_idle("rst");
    chk("rst_id", 32'(grant_id), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    req   = 5'b00000;
    step();
  endtask

  initial begin
    int order [6] = '{0, 1, 2, 3, 4, 0};
    logic exp_valid;
    logic exp_to;

    rst_n = 1'b0;
    req   = 5'b00000;
    do_reset();

    // single requester
    req = 5'b00100;
    step();
    chk_owner("single", 2);
    req = 5'b00000;
    step();
    chk_idle("single_rel");
    chk("single_id_hold", 32'(grant_id), 32'd2);

    // fairness and wrap from pointer 0
    do_reset();
    req = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      step();
      chk_owner($sformatf("rr%0d", k), order[k]);
      step();
      chk_owner($sformatf("rr%0d_hold", k), order[k]);
      req[order[k]] = 1'b0;
      step();
      chk_idle($sformatf("rr%0d_gap", k));
      req = 5'b11111;
    end
    req = 5'b00000;
    step();

    // no preemption, next owner is 4 when it requests
    req = 5'b01000;
    step();
    chk_owner("np_a", 3);
    req = 5'b01001;
    step();
    chk("np_a_hold1", 32'(grant), 32'b01000);
    step();
    chk("np_a_hold2", 32'(grant), 32'b01000);
    req = 5'b10001;
    step();
    chk_idle("np_a_rel");
    step();
    chk_owner("np_a_next", 4);
    req = 5'b00001;
    step();
    chk_idle("np_a_rel4");
    step();
    chk_owner("np_a_wrap", 0);
    req = 5'b00000;
    step();

    // no preemption, next owner wraps to 0 when 4 is quiet
    req = 5'b01000;
    step();
    chk_owner("np_b", 3);
    req = 5'b01001;
    step();
    chk("np_b_hold", 32'(grant), 32'b01000);
    req = 5'b00001;
    step();
    chk_idle("np_b_rel");
    step();
    chk_owner("np_b_next", 0);
    req = 5'b00000;
    step();

    // asynchronous reset in the middle of a grant
    req = 5'b00010;
    step();
    chk_owner("mid", 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_id", 32'(grant_id), 32'd0);
    rst_n = 1'b1;
    step();
    chk_owner("mid_after", 1);
    req = 5'b00000;
    step();

    // long hold: revoked after 8 cycles only when the timer is built in
    req = 5'b00100;
    step();
    chk_owner("to_start", 2);
    for (int s = 1; s < 20; s++) begin
      step();
`ifdef DEMUX_ARBITER_TIMEOUT_EN
      exp_valid = (s < 8);
      exp_to    = (s == 8);
`else
      exp_valid = 1'b1;
      exp_to    = 1'b0;
`endif
      chk($sformatf("to_valid_c%0d", s), 32'(grant_valid), 32'(exp_valid));
      chk($sformatf("to_pulse_c%0d", s), 32'(timeout), 32'(exp_to));
    end
    req = 5'b00000;
    step();
    chk_idle("to_rel");
    chk("to_rel_pulse", 32'(timeout), 32'd0);
    req = 5'b00100;
    step();
    chk_owner("to_unblocked", 2);
    req = 5'b00000;
    step();
    chk_idle("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
